bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble).
- Sits directly upstream of the four-digit seven-segment decoder. Its 16-bit `registrador` output drives the decoder's 16-bit BCD input.
- Nibble layout: [3:0] units, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- Any out-of-range or blanked digit is driven as 4'hF, which the decoder renders as all segments off.

---
 rtl/bin2bcd_seq_if.sv | 35 +++
 rtl/bin2bcd_seq.sv | 147 ++++++++++++++
 tb/tb_bin2bcd_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_if
// Purpose  : Start/result bundle between a requester and bin2bcd_seq.
// Revision : 1.0
// ============================================================================
interface bin2bcd_seq_if #(
  parameter int IN_W = 14
) ();
  logic [IN_W-1:0] bin;
  logic            start;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [15:0]     registrador;

  modport master (
    output bin,
    output start,
    input  busy,
    input  done,
    input  ovf,
    input  registrador
  );

  modport slave (
    input  bin,
    input  start,
    output busy,
    output done,
    output ovf,
    output registrador
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Sequential double-dabble binary to 4-digit packed BCD converter.
//            BIN2BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits to 4'hF.
// Revision : 1.0
// ============================================================================
module bin2bcd_seq #(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = 9999
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int          c_CNT_W   = $clog2(IN_W + 1);
  localparam logic [31:0] c_MAX_VAL = 32'(MAX_VAL);

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  localparam logic [15:0] c_REG_RST = 16'hFFF0;
`else
  localparam logic [15:0] c_REG_RST = 16'h0000;
`endif

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t              r_state,    w_state_nxt;
  logic [IN_W-1:0]     r_shift,    w_shift_nxt;
  logic [15:0]         r_scratch,  w_scratch_nxt;
  logic [c_CNT_W-1:0]  r_cnt,      w_cnt_nxt;
  logic                r_ovf_mark, w_ovf_mark_nxt;
  logic                r_done,     w_done_nxt;
  logic                r_ovf,      w_ovf_nxt;
  logic [15:0]         r_reg,      w_reg_nxt;

  logic [15:0]         w_adj;
  logic [15:0]         w_norm;
  logic                w_bin_ovf;

  // Per-nibble add-3 correction; no carry crosses a nibble boundary.
  for (genvar k = 0; k < 4; k++) begin : g_adj
    assign w_adj[4*k +: 4] = (r_scratch[4*k +: 4] >= 4'd5) ?
                             (r_scratch[4*k +: 4] + 4'd3) :
                             r_scratch[4*k +: 4];
  end

  assign w_bin_ovf = ({{(32-IN_W){1'b0}}, bus.bin} > c_MAX_VAL);

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  function automatic logic [15:0] f_blank(input logic [15:0] v);
    logic [15:0] t;
    t = v;
    if (t[15:12] == 4'd0) begin
      t[15:12] = 4'hF;
      if (t[11:8] == 4'd0) begin
        t[11:8] = 4'hF;
        if (t[7:4] == 4'd0) begin
          t[7:4] = 4'hF;
        end
      end
    end
    return t;
  endfunction

  assign w_norm = f_blank(r_scratch);
`else
  assign w_norm = r_scratch;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_scratch_nxt  = r_scratch;
    w_cnt_nxt      = r_cnt;
    w_ovf_mark_nxt = r_ovf_mark;
    w_done_nxt     = 1'b0;
    w_ovf_nxt      = r_ovf;
    w_reg_nxt      = r_reg;

    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_shift_nxt    = bus.bin;
          w_scratch_nxt  = 16'h0000;
          w_cnt_nxt      = c_CNT_W'(IN_W);
          w_ovf_mark_nxt = w_bin_ovf;
          w_state_nxt    = w_bin_ovf ? ST_FINISH : ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // Bit 15 of the adjusted scratch falls off; inputs <= MAX_VAL never reach it.
        w_scratch_nxt = {w_adj[14:0], r_shift[IN_W-1]};
        w_shift_nxt   = {r_shift[IN_W-2:0], 1'b0};
        w_cnt_nxt     = r_cnt - c_CNT_W'(1);
        if (r_cnt == c_CNT_W'(1)) begin
          w_state_nxt = ST_FINISH;
        end
      end

      ST_FINISH: begin
        w_reg_nxt   = r_ovf_mark ? 16'hFFFF : w_norm;
        w_ovf_nxt   = r_ovf_mark;
        w_done_nxt  = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_scratch  <= 16'h0000;
      r_cnt      <= '0;
      r_ovf_mark <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_reg      <= c_REG_RST;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_scratch  <= w_scratch_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ovf_mark <= w_ovf_mark_nxt;
      r_done     <= w_done_nxt;
      r_ovf      <= w_ovf_nxt;
      r_reg      <= w_reg_nxt;
    end
  end

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = r_done;
  assign bus.ovf         = r_ovf;
  assign bus.registrador = r_reg;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Directed self-checking bench for bin2bcd_seq with result scoreboard.
// Revision : 1.0
// ============================================================================
module tb_bin2bcd_seq;
  localparam int IN_W = 14;
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  localparam logic [15:0] c_REG_RST = 16'hFFF0;
`else
  localparam logic [15:0] c_REG_RST = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bin2bcd_seq_if #(.IN_W(IN_W)) bus ();

  bin2bcd_seq #(.IN_W(IN_W), .MAX_VAL(9999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          cyc    = 0;
  logic        rst_seen = 1'b1;
  logic [15:0] last_pub = c_REG_RST;
  logic [16:0] sb_q[$];

  function automatic logic [15:0] model(input int v);
    logic [15:0] r;
    if (v > 9999) return 16'hFFFF;
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    if (v < 1000) r[15:12] = 4'hF;
    if (v < 100)  r[11:8]  = 4'hF;
    if (v < 10)   r[7:4]   = 4'hF;
`endif
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  // Scoreboard and hold-stability monitor.
  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_seen) begin
      last_pub = c_REG_RST;
    end else if (bus.done) begin
      n_done++;
      chk("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_reg", bus.registrador, e[15:0]);
        chk("sb_ovf", bus.ovf, e[16]);
      end
      last_pub = bus.registrador;
    end else begin
      chk("reg_stable", bus.registrador, last_pub);
    end
  end

  task automatic push_exp(input int v);
    sb_q.push_back({(v > 9999) ? 1'b1 : 1'b0, model(v)});
  endtask

  task automatic wait_done(output int c);
    logic got;
    got = 1'b0;
    c = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        c = cyc;
        break;
      end
    end
    chk("done_timeout", 32'(got), 32'd1);
  endtask

  task automatic run_conv(input int v, input int exp_busy);
    int nb;
    nb = 0;
    bus.bin   = IN_W'(v);
    bus.start = 1'b1;
    push_exp(v);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 40 && bus.busy; i++) begin
      nb++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(nb), 32'(exp_busy));
    chk("done_on_idle", bus.done, 1'b1);
    @(negedge clk);
    chk("done_single", bus.done, 1'b0);
  endtask

  initial begin
    int c0, c1, d0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_reg",  bus.registrador, c_REG_RST);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_ovf",  bus.ovf, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    run_conv(1234, 15);
    run_conv(0, 15);
    run_conv(9999, 15);
    run_conv(10000, 1);
    chk("ovf_sticky", bus.ovf, 1'b1);
    run_conv(7, 15);
    chk("ovf_cleared", bus.ovf, 1'b0);

    // Start pulse while busy must be dropped.
    d0 = n_done;
    bus.bin = IN_W'(5678);
    bus.start = 1'b1;
    push_exp(5678);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.bin = IN_W'(1111);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(c0);
    repeat (20) @(negedge clk);
    chk("busy_start_ignored", 32'(n_done - d0), 32'd1);

    // Reset in the middle of a conversion.
    d0 = n_done;
    bus.bin = IN_W'(4321);
    bus.start = 1'b1;
    push_exp(4321);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_reg", bus.registrador, c_REG_RST);
    sb_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_nodone", 32'(n_done - d0), 32'd0);
    run_conv(4321, 15);

    run_conv(42, 15);
    run_conv(305, 15);
    run_conv(0, 15);

    // Start held high across two conversions.
    bus.bin = IN_W'(8);
    bus.start = 1'b1;
    push_exp(8);
    wait_done(c0);
    bus.bin = IN_W'(9);
    push_exp(9);
    wait_done(c1);
    bus.start = 1'b0;
    chk("b2b_spacing", 32'(c1 - c0), 32'd16);
    repeat (20) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
